// File: rtl/block_read_accumulator.sv
// block_read_accumulator
// Requests one block read from the multiplier and reduces the returned burst
// of products to sum, maximum and beat count. The result is then offered on
// a valid/ready port.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; results from the last block are held
// REQ    | EN_blockRead asserted, waiting for the first product beat
// STREAM | accepting one beat per cycle until VALID drops or block full
// DONE   | result presented, waiting for res_ready
module block_read_accumulator #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      EN_blockRead,
    input  logic                      VALID_memVal,
    input  logic [WIDTH-1:0]          memVal_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH+LOGDEPTH-1:0] res_sum,
    output logic [WIDTH-1:0]          res_max,
    output logic [LOGDEPTH:0]         res_count,
    output logic                      res_timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [LOGDEPTH:0] MAX_BEATS = (LOGDEPTH+1)'(1) << LOGDEPTH;
    localparam logic [CW-1:0]     WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             wait_cnt;
    logic [LOGDEPTH:0]         count_inc;
    logic [WIDTH+LOGDEPTH-1:0] sum_inc;
    logic [WIDTH-1:0]          max_upd;

    // Accumulator values that accepting the current beat would produce.
    always_comb begin
        count_inc = res_count + (LOGDEPTH+1)'(1);
        sum_inc   = res_sum + {{LOGDEPTH{1'b0}}, memVal_data};
        max_upd   = (memVal_data > res_max) ? memVal_data : res_max;
    end

    // Sequencing FSM; the result registers double as the accumulators.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            busy         <= 1'b0;
            EN_blockRead <= 1'b0;
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_max      <= '0;
            res_count    <= '0;
            res_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= REQ;
                        busy         <= 1'b1;
                        EN_blockRead <= 1'b1;
                        wait_cnt     <= '0;
                        res_sum      <= '0;
                        res_max      <= '0;
                        res_count    <= '0;
                        res_timeout  <= 1'b0;
                    end
                end
                REQ: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (VALID_memVal) begin
                        EN_blockRead <= 1'b0;
                        res_sum      <= sum_inc;
                        res_max      <= max_upd;
                        res_count    <= count_inc;
                        if (count_inc == MAX_BEATS) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= DONE;
                        EN_blockRead <= 1'b0;
                        res_valid    <= 1'b1;
                        res_timeout  <= 1'b1;
                        res_count    <= '0;
                    end
                end
                STREAM: begin
                    if (VALID_memVal) begin
                        res_sum   <= sum_inc;
                        res_max   <= max_upd;
                        res_count <= count_inc;
                        if (count_inc == MAX_BEATS) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end
                    end else begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    EN_blockRead <= 1'b0;
                    res_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_read_accumulator.sv
// Self-checking bench for block_read_accumulator with a behavioural model.
module tb_block_read_accumulator;

    localparam int LD = 6;
    localparam int W  = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              EN_blockRead;
    logic              VALID_memVal;
    logic [W-1:0]      memVal_data;
    logic              res_valid;
    logic              res_ready;
    logic [W+LD-1:0]   res_sum;
    logic [W-1:0]      res_max;
    logic [LD:0]       res_count;
    logic              res_timeout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    beats [0:127];
    logic [W+LD-1:0] exp_sum;
    logic [W-1:0]    exp_max;
    logic [LD:0]     exp_cnt;
    logic            exp_to;

    block_read_accumulator #(.LOGDEPTH(LD), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .EN_blockRead(EN_blockRead), .VALID_memVal(VALID_memVal),
        .memVal_data(memVal_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_max(res_max), .res_count(res_count),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    // Reference: the block is the first min(n, 2**LD) beats, unless no beat
    // arrives within TO cycles of the request (or none is sent at all).
    function automatic void model(int d, int n);
        longint s = 0;
        longint m = 0;
        int     c = 0;
        exp_to = (n == 0 || d >= TO);
        if (!exp_to) begin
            for (int i = 0; i < n && i < (1 << LD); i++) begin
                s += longint'(beats[i]);
                if (longint'(beats[i]) > m) m = longint'(beats[i]);
                c++;
            end
        end
        exp_sum = (W+LD)'(s);
        exp_max = W'(m);
        exp_cnt = (LD+1)'(c);
    endfunction

    // Start a block, idle d cycles, then present n beats back to back.
    task automatic drive_block(int d, int n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = beats[i];
            @(negedge clk);
        end
        VALID_memVal = 1'b0;
        memVal_data  = $urandom;
    endtask

    task automatic wait_valid(output bit ok);
        int cyc = 0;
        while (res_valid !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        ok = (res_valid === 1'b1);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; VALID_memVal = 1'b0; memVal_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, EN_blockRead, res_valid, res_timeout} !== 4'b0 || res_sum !== '0 ||
            res_max !== '0 || res_count !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b en=%b valid=%b to=%b sum=%0h max=%0h cnt=%0d, required all zero",
                     busy, EN_blockRead, res_valid, res_timeout, res_sum, res_max, res_count);
        end
    endtask

    task automatic test_burst();
        bit ok;
        for (int i = 0; i < 63; i++) beats[i] = W'(i + 1);
        drive_block(0, 63);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL burst_early_valid: got %b required 0", res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1) begin
            errors++; $display("FAIL burst_latency: res_valid=%b required 1", res_valid);
        end
        wait_valid(ok);
        model(0, 63);
        checks++;
        if (!ok || res_count !== exp_cnt || res_sum !== exp_sum || res_max !== exp_max || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL burst63: cnt=%0d sum=%0d max=%0d to=%b, required cnt=%0d sum=%0d max=%0d to=0",
                     res_count, res_sum, res_max, res_timeout, exp_cnt, exp_sum, exp_max);
        end
        release_result();
    endtask

    task automatic test_full_block();
        bit ok;
        for (int i = 0; i < 66; i++) beats[i] = 32'hFFFF_FFFF;
        drive_block(0, 66);
        wait_valid(ok);
        checks++;
        if (!ok || res_count !== 7'd64 || res_sum !== 38'h3F_FFFF_FFC0 || res_max !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL full_block: cnt=%0d sum=%0h max=%0h, required cnt=64 sum=3fffffffc0 max=ffffffff",
                     res_count, res_sum, res_max);
        end
        release_result();
    endtask

    task automatic test_timeout();
        int en_cyc = 0;
        bit ok;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (EN_blockRead === 1'b1 && en_cyc < 40) begin
            en_cyc++;
            @(negedge clk);
        end
        checks++;
        if (en_cyc != TO) begin
            errors++; $display("FAIL timeout_en_len: EN high %0d cycles, required %0d", en_cyc, TO);
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++; $display("FAIL timeout_valid: res_valid=%b required 1", res_valid);
        end
        wait_valid(ok);
        checks++;
        if (!ok || res_timeout !== 1'b1 || res_count !== '0 || res_sum !== '0 || res_max !== '0) begin
            errors++;
            $display("FAIL timeout_result: to=%b cnt=%0d sum=%0d max=%0d, required to=1 cnt=0 sum=0 max=0",
                     res_timeout, res_count, res_sum, res_max);
        end
        release_result();
    endtask

    task automatic test_hold();
        bit ok;
        beats[0] = 32'd5;
        drive_block(0, 1);
        wait_valid(ok);
        checks++;
        if (!ok || res_count !== 7'd1 || res_sum !== 38'd5 || res_max !== 32'd5) begin
            errors++;
            $display("FAIL single_beat: cnt=%0d sum=%0d max=%0d, required 1 5 5", res_count, res_sum, res_max);
        end
        for (int i = 0; i < 10; i++) begin
            start = 1'(i % 2);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || busy !== 1'b1 || res_count !== 7'd1 || res_sum !== 38'd5 ||
                res_max !== 32'd5 || EN_blockRead !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b busy=%b en=%b cnt=%0d sum=%0d max=%0d, required 1 1 0 1 5 5",
                         i, res_valid, busy, EN_blockRead, res_count, res_sum, res_max);
            end
        end
        start = 1'b1;
        release_result();
        start = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_count !== 7'd1 || res_sum !== 38'd5) begin
            errors++;
            $display("FAIL handshake: valid=%b busy=%b cnt=%0d sum=%0d, required 0 0 1 5",
                     res_valid, busy, res_count, res_sum);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || EN_blockRead !== 1'b0) begin
            errors++; $display("FAIL start_with_ready: busy=%b en=%b required 0 0", busy, EN_blockRead);
        end
    endtask

    task automatic test_reset_midblock();
        bit ok;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = W'(i + 1);
            if (i == 19) rst_n = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b1;
        checks++;
        if (EN_blockRead !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || res_count !== '0) begin
            errors++;
            $display("FAIL midreset: en=%b valid=%b busy=%b cnt=%0d, required 0 0 0 0",
                     EN_blockRead, res_valid, busy, res_count);
        end
        repeat (5) begin
            memVal_data = $urandom;
            @(negedge clk);
        end
        VALID_memVal = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_count !== '0) begin
            errors++;
            $display("FAIL idle_drop: busy=%b valid=%b cnt=%0d, required 0 0 0", busy, res_valid, res_count);
        end
        beats[0] = 32'd7; beats[1] = 32'd2; beats[2] = 32'd9;
        drive_block(2, 3);
        wait_valid(ok);
        checks++;
        if (!ok || res_count !== 7'd3 || res_sum !== 38'd18 || res_max !== 32'd9 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: cnt=%0d sum=%0d max=%0d to=%b, required 3 18 9 0",
                     res_count, res_sum, res_max, res_timeout);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int blk = 0; blk < 24; blk++) begin
            int d = (blk % 6 == 5) ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, TO - 1));
            int n = (blk % 8 == 7) ? int'($urandom_range(64, 70)) : int'($urandom_range(0, 40));
            for (int i = 0; i < n; i++)
                beats[i] = (blk % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 255));
            model(d, n);
            drive_block(d, n);
            wait_valid(ok);
            checks++;
            if (!ok || res_count !== exp_cnt || res_sum !== exp_sum || res_max !== exp_max || res_timeout !== exp_to) begin
                errors++;
                $display("FAIL b2b_%0d (d=%0d n=%0d): cnt=%0d sum=%0h max=%0h to=%b, required cnt=%0d sum=%0h max=%0h to=%b",
                         blk, d, n, res_count, res_sum, res_max, res_timeout, exp_cnt, exp_sum, exp_max, exp_to);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_full_block();
        test_timeout();
        test_hold();
        test_reset_midblock();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
